// File: rtl/hist_eq_pkg.sv
// Shared types and constants for the hist_eq_module configuration controller.
// The parameter-set struct is sized by HIST_EQ_DW and matches the controller's default DATA_WIDTH.
package hist_eq_pkg;

  localparam int HIST_EQ_DW = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } hist_eq_ctrl_state_t;

  localparam logic [1:0] CFG_ADDR_CONTRAST = 2'd0;
  localparam logic [1:0] CFG_ADDR_UPPER    = 2'd1;
  localparam logic [1:0] CFG_ADDR_LOWER    = 2'd2;
  localparam logic [1:0] CFG_ADDR_THR_EN   = 2'd3;

  typedef struct packed {
    logic [HIST_EQ_DW-1:0] contrast;
    logic [HIST_EQ_DW-1:0] upper;
    logic [HIST_EQ_DW-1:0] lower;
    logic                  thr_en;
  } hist_eq_cfg_t;

  // A parameter set is usable only if its band is non-empty.
  function automatic logic cfg_is_valid(input hist_eq_cfg_t c);
    return c.lower < c.upper;
  endfunction

endpackage

// File: rtl/hist_eq_ctrl_if.sv
// AXI-Stream handshake bundle observed by the controller.
// The master modport drives the stream; the slave modport only watches it.
interface hist_eq_ctrl_if;
  logic tvalid;
  logic tready;
  logic tuser;
  logic tlast;

  modport master (output tvalid, output tready, output tuser, output tlast);
  modport slave  (input tvalid, input tready, input tuser, input tlast);
endinterface

// File: rtl/hist_eq_frame_tracker.sv
// Frame/line geometry tracker: FSM, x/y counters, length errors and frame-done pulse.
// state     | meaning
// ST_IDLE   | between frames, waiting for an SOF beat
// ST_ACTIVE | frame in progress, counting pixels and lines
module hist_eq_frame_tracker
  import hist_eq_pkg::*;
#(
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 1024
) (
  input  logic        i_sys_clk,
  input  logic        i_sys_aresetn,
  input  logic        i_beat,
  input  logic        i_tuser,
  input  logic        i_tlast,
  input  logic        i_err_clr,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic [15:0] o_frame_cnt,
  output logic        o_err_line_len,
  output logic        o_err_frame_len,
  output logic        o_frame_end,
  output logic        o_sof_idle
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  hist_eq_ctrl_state_t state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          err_line_q, err_line_d;
  logic          err_frame_q, err_frame_d;
  logic          line_bad, sof_restart, frame_end, sof_idle;

  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
    if (!i_sys_aresetn) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
      err_line_q  <= 1'b0;
      err_frame_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
      err_line_q  <= err_line_d;
      err_frame_q <= err_frame_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    line_bad    = 1'b0;
    sof_restart = 1'b0;
    frame_end   = 1'b0;
    sof_idle    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_beat && i_tuser) begin
          sof_idle = 1'b1;
          state_d  = ST_ACTIVE;
          x_d      = XW'(1);
          y_d      = '0;
        end
      end
      ST_ACTIVE: begin
        if (i_beat && i_tuser) begin
          sof_restart = 1'b1;
          x_d         = XW'(1);
          y_d         = '0;
        end else if (i_beat) begin
          // A line ends on tlast or is forced to end at the last pixel slot.
          line_bad = i_tlast != (x_q == X_LAST);
          if (i_tlast || (x_q == X_LAST)) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              frame_end = 1'b1;
              state_d   = ST_IDLE;
              y_d       = '0;
            end else begin
              y_d = y_q + 1'b1;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_d      = (state_d == ST_ACTIVE);
    done_d      = frame_end;
    cnt_d       = cnt_q + {15'd0, frame_end};
    err_line_d  = line_bad | (err_line_q & ~i_err_clr);
    err_frame_d = sof_restart | (err_frame_q & ~i_err_clr);
  end

  assign o_busy          = busy_q;
  assign o_frame_done    = done_q;
  assign o_frame_cnt     = cnt_q;
  assign o_err_line_len  = err_line_q;
  assign o_err_frame_len = err_frame_q;
  assign o_frame_end     = frame_end;
  assign o_sof_idle      = sof_idle;

endmodule

// File: rtl/hist_eq_ctrl.sv
// Frame-synchronous parameter controller for hist_eq_module: shadow, staged and active
// parameter sets, with the active set only updated between frames.
module hist_eq_ctrl
  import hist_eq_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int WIDTH        = 1280,
  parameter int HEIGHT       = 1024,
  parameter int DEF_CONTRAST = 170,
  parameter int DEF_UPPER    = 250,
  parameter int DEF_LOWER    = 100,
  parameter int DEF_THR_EN   = 1
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_aresetn,
  input  logic                  i_cfg_wr,
  input  logic [1:0]            i_cfg_addr,
  input  logic [DATA_WIDTH-1:0] i_cfg_wdata,
  input  logic                  i_cfg_commit,
  input  logic                  i_err_clr,
  hist_eq_ctrl_if.slave         s_axis,
  output logic [DATA_WIDTH-1:0] o_contrast_threshold,
  output logic [DATA_WIDTH-1:0] o_upper_bound,
  output logic [DATA_WIDTH-1:0] o_lower_bound,
  output logic                  o_thresholding_en,
  output logic                  o_cfg_pending,
  output logic                  o_cfg_err,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic [15:0]           o_frame_cnt,
  output logic                  o_err_line_len,
  output logic                  o_err_frame_len
);

  localparam hist_eq_cfg_t CFG_DEF = '{
    contrast: HIST_EQ_DW'(DEF_CONTRAST),
    upper:    HIST_EQ_DW'(DEF_UPPER),
    lower:    HIST_EQ_DW'(DEF_LOWER),
    thr_en:   1'(DEF_THR_EN)
  };

  hist_eq_cfg_t shadow_q, shadow_d;
  hist_eq_cfg_t staged_q, staged_d;
  hist_eq_cfg_t active_q, active_d;
  logic         pending_q, pending_d;
  logic         cfg_err_q, cfg_err_d;
  logic         beat, frame_end, sof_idle, busy;
  logic         commit_ok, apply;

  assign beat = s_axis.tvalid & s_axis.tready;

  hist_eq_frame_tracker #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_tracker (
    .i_sys_clk       (i_sys_clk),
    .i_sys_aresetn   (i_sys_aresetn),
    .i_beat          (beat),
    .i_tuser         (s_axis.tuser),
    .i_tlast         (s_axis.tlast),
    .i_err_clr       (i_err_clr),
    .o_busy          (busy),
    .o_frame_done    (o_frame_done),
    .o_frame_cnt     (o_frame_cnt),
    .o_err_line_len  (o_err_line_len),
    .o_err_frame_len (o_err_frame_len),
    .o_frame_end     (frame_end),
    .o_sof_idle      (sof_idle)
  );

  always_comb begin
    shadow_d = shadow_q;
    if (i_cfg_wr) begin
      case (i_cfg_addr)
        CFG_ADDR_CONTRAST: shadow_d.contrast = HIST_EQ_DW'(i_cfg_wdata);
        CFG_ADDR_UPPER:    shadow_d.upper    = HIST_EQ_DW'(i_cfg_wdata);
        CFG_ADDR_LOWER:    shadow_d.lower    = HIST_EQ_DW'(i_cfg_wdata);
        default:           shadow_d.thr_en   = i_cfg_wdata[0];
      endcase
    end
  end

  // An SOF in IDLE blocks application so the new frame runs entirely on the old set.
  always_comb begin
    commit_ok = i_cfg_commit & cfg_is_valid(shadow_q);
    apply     = pending_q & ((~busy & ~sof_idle) | frame_end);
    staged_d  = commit_ok ? shadow_q : staged_q;
    active_d  = apply ? staged_q : active_q;
    pending_d = commit_ok | (pending_q & ~apply);
    cfg_err_d = i_cfg_commit & ~cfg_is_valid(shadow_q);
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
    if (!i_sys_aresetn) begin
      shadow_q  <= CFG_DEF;
      staged_q  <= CFG_DEF;
      active_q  <= CFG_DEF;
      pending_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      staged_q  <= staged_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign o_contrast_threshold = DATA_WIDTH'(active_q.contrast);
  assign o_upper_bound        = DATA_WIDTH'(active_q.upper);
  assign o_lower_bound        = DATA_WIDTH'(active_q.lower);
  assign o_thresholding_en    = active_q.thr_en;
  assign o_cfg_pending        = pending_q;
  assign o_cfg_err            = cfg_err_q;
  assign o_busy               = busy;

endmodule

// File: tb/tb_hist_eq_ctrl.sv
// Directed bench for hist_eq_ctrl with a 16x8 frame geometry.
module tb_hist_eq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cfg_wr;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic       cfg_commit;
  logic       err_clr;
  logic [7:0] o_contrast, o_upper, o_lower;
  logic       o_thr_en, o_pending, o_cfg_err, o_busy, o_done;
  logic [15:0] o_cnt;
  logic       o_err_line, o_err_frame;

  int n_tests = 0;
  int n_fail  = 0;
  bit seen_done;

  hist_eq_ctrl_if s_if ();

  hist_eq_ctrl #(
    .DATA_WIDTH (8),
    .WIDTH      (16),
    .HEIGHT     (8)
  ) dut (
    .i_sys_clk            (clk),
    .i_sys_aresetn        (rst_n),
    .i_cfg_wr             (cfg_wr),
    .i_cfg_addr           (cfg_addr),
    .i_cfg_wdata          (cfg_wdata),
    .i_cfg_commit         (cfg_commit),
    .i_err_clr            (err_clr),
    .s_axis               (s_if),
    .o_contrast_threshold (o_contrast),
    .o_upper_bound        (o_upper),
    .o_lower_bound        (o_lower),
    .o_thresholding_en    (o_thr_en),
    .o_cfg_pending        (o_pending),
    .o_cfg_err            (o_cfg_err),
    .o_busy               (o_busy),
    .o_frame_done         (o_done),
    .o_frame_cnt          (o_cnt),
    .o_err_line_len       (o_err_line),
    .o_err_frame_len      (o_err_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic u, input logic l);
    s_if.tvalid = 1'b1;
    s_if.tready = 1'b1;
    s_if.tuser  = u;
    s_if.tlast  = l;
    tick();
    s_if.tvalid = 1'b0;
    s_if.tuser  = 1'b0;
    s_if.tlast  = 1'b0;
    if (o_done) seen_done = 1'b1;
  endtask

  // first beat carries tuser when sof=1; tlast placed on the final beat when tl=1
  task automatic send_line(input bit sof, input int len, input bit tl);
    for (int i = 0; i < len; i++) beat(sof && (i == 0), tl && (i == len - 1));
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cfg_wr = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'd0;
    cfg_commit = 1'b0; err_clr = 1'b0;
    s_if.tvalid = 1'b0; s_if.tready = 1'b0; s_if.tuser = 1'b0; s_if.tlast = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // reset state
    chk("rst_contrast", 32'(o_contrast), 32'd170);
    chk("rst_upper", 32'(o_upper), 32'd250);
    chk("rst_lower", 32'(o_lower), 32'd100);
    chk("rst_thr_en", 32'(o_thr_en), 32'd1);
    chk("rst_flags", {26'd0, o_busy, o_pending, o_cfg_err, o_done, o_err_line, o_err_frame}, 32'd0);
    chk("rst_cnt", 32'(o_cnt), 32'd0);

    // IDLE commit
    wr(2'd0, 8'd200);
    commit();
    chk("idle_pend_t", 32'(o_pending), 32'd1);
    chk("idle_contrast_t", 32'(o_contrast), 32'd170);
    tick();
    chk("idle_contrast_t1", 32'(o_contrast), 32'd200);
    chk("idle_pend_t1", 32'(o_pending), 32'd0);

    // non-SOF beat and unready SOF are both ignored in IDLE
    beat(1'b0, 1'b1);
    chk("idle_nonsof", 32'(o_busy), 32'd0);
    s_if.tvalid = 1'b1; s_if.tready = 1'b0; s_if.tuser = 1'b1;
    tick();
    s_if.tvalid = 1'b0; s_if.tuser = 1'b0;
    chk("idle_notready", 32'(o_busy), 32'd0);

    // frame 1: mid-frame commit of lower=50
    seen_done = 1'b0;
    send_line(1'b1, 16, 1'b1);
    chk("f1_busy", 32'(o_busy), 32'd1);
    send_line(1'b0, 16, 1'b1);
    send_line(1'b0, 16, 1'b1);
    send_line(1'b0, 8, 1'b0);
    wr(2'd2, 8'd50);
    commit();
    chk("f1_pend", 32'(o_pending), 32'd1);
    chk("f1_lower_hold", 32'(o_lower), 32'd100);
    for (int i = 0; i < 8; i++) beat(1'b0, i == 7);
    for (int l = 4; l < 7; l++) send_line(1'b0, 16, 1'b1);
    send_line(1'b0, 15, 1'b0);
    chk("f1_lower_pre", 32'(o_lower), 32'd100);
    chk("f1_nodone_pre", 32'(seen_done), 32'd0);
    beat(1'b0, 1'b1);
    chk("f1_lower_post", 32'(o_lower), 32'd50);
    chk("f1_done", 32'(o_done), 32'd1);
    chk("f1_busy_post", 32'(o_busy), 32'd0);
    chk("f1_cnt", 32'(o_cnt), 32'd1);
    chk("f1_pend_post", 32'(o_pending), 32'd0);
    chk("f1_errs", {30'd0, o_err_line, o_err_frame}, 32'd0);
    tick();
    chk("f1_done_pulse", 32'(o_done), 32'd0);

    // frame 2: short line on line 2, err_clr in same cycle as the set
    send_line(1'b1, 16, 1'b1);
    send_line(1'b0, 16, 1'b1);
    send_line(1'b0, 9, 1'b0);
    err_clr = 1'b1;
    beat(1'b0, 1'b1);
    err_clr = 1'b0;
    chk("f2_err_line", 32'(o_err_line), 32'd1);
    seen_done = 1'b0;
    for (int l = 3; l < 7; l++) send_line(1'b0, 16, 1'b1);
    chk("f2_nodone_pre", 32'(seen_done), 32'd0);
    send_line(1'b0, 16, 1'b1);
    chk("f2_done", 32'(o_done), 32'd1);
    chk("f2_cnt", 32'(o_cnt), 32'd2);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("f2_err_clr", 32'(o_err_line), 32'd0);

    // frame 3: early SOF on line 4
    for (int l = 0; l < 4; l++) send_line(l == 0, 16, 1'b1);
    seen_done = 1'b0;
    send_line(1'b1, 16, 1'b1);
    chk("f3_err_frame", 32'(o_err_frame), 32'd1);
    chk("f3_err_line", 32'(o_err_line), 32'd0);
    for (int l = 1; l < 7; l++) send_line(1'b0, 16, 1'b1);
    send_line(1'b0, 15, 1'b0);
    chk("f3_nodone_pre", 32'(seen_done), 32'd0);
    chk("f3_busy_pre", 32'(o_busy), 32'd1);
    beat(1'b0, 1'b1);
    chk("f3_done", 32'(o_done), 32'd1);
    chk("f3_cnt", 32'(o_cnt), 32'd3);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("f3_err_clr", 32'(o_err_frame), 32'd0);

    // invalid commit: lower=250, upper=100
    wr(2'd2, 8'd250);
    wr(2'd1, 8'd100);
    commit();
    chk("inv_err", 32'(o_cfg_err), 32'd1);
    chk("inv_pend", 32'(o_pending), 32'd0);
    tick();
    chk("inv_err_pulse", 32'(o_cfg_err), 32'd0);
    chk("inv_outputs", {o_contrast, o_upper, o_lower, 7'd0, o_thr_en}, {8'd200, 8'd250, 8'd50, 8'd1});

    // frame 4: commit then SOF on the next edge defers application; line 0 force-ended
    wr(2'd1, 8'd251);
    wr(2'd3, 8'd0);
    commit();
    chk("f4_pend", 32'(o_pending), 32'd1);
    beat(1'b1, 1'b0);
    chk("f4_deferred", {o_upper, o_lower, 7'd0, o_thr_en}, {8'd250, 8'd50, 8'd1});
    chk("f4_pend_hold", 32'(o_pending), 32'd1);
    send_line(1'b0, 15, 1'b0);
    chk("f4_force_end", 32'(o_err_line), 32'd1);
    for (int l = 1; l < 7; l++) send_line(1'b0, 16, 1'b1);
    chk("f4_hold_pre", 32'(o_thr_en), 32'd1);
    send_line(1'b0, 16, 1'b1);
    chk("f4_done", 32'(o_done), 32'd1);
    chk("f4_applied", {o_contrast, o_upper, o_lower, 7'd0, o_thr_en}, {8'd200, 8'd251, 8'd250, 8'd0});
    chk("f4_cnt", 32'(o_cnt), 32'd4);

    // reset mid-frame discards the staged set
    beat(1'b1, 1'b0);
    wr(2'd0, 8'd5);
    commit();
    chk("mr_pend", 32'(o_pending), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_params", {o_contrast, o_upper, o_lower, 7'd0, o_thr_en}, {8'd170, 8'd250, 8'd100, 8'd1});
    chk("mr_state", {29'd0, o_busy, o_pending, o_err_line}, 32'd0);
    chk("mr_cnt", 32'(o_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("mr_discard", {o_contrast, 7'd0, o_pending}, {8'd170, 8'd0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hist_eq_ctrl.md
# hist_eq_ctrl

Frame-synchronous configuration controller for `hist_eq_module`. It holds shadow copies of the contrast threshold, upper and lower bound, and thresholding-enable parameters, and applies them only between frames. It also tracks the input video stream's line and frame geometry. It sits beside `hist_eq_module`: it drives the module's four parameter ports and passively monitors its `s_axis` handshake.

## Interface
Parameters:
- `DATA_WIDTH`, 8: parameter value width.
- `WIDTH`, 1280: pixels per line; must be ≥ 2.
- `HEIGHT`, 1024: lines per frame; must be ≥ 1.
- `DEF_CONTRAST`, 170: reset value of `o_contrast_threshold`.
- `DEF_UPPER`, 250: reset value of `o_upper_bound`.
- `DEF_LOWER`, 100: reset value of `o_lower_bound`.
- `DEF_THR_EN`, 1: reset value of `o_thresholding_en`.

Ports (one clock; reset is asynchronous and active-low):
- `i_sys_clk`  in  1  system clock.
- `i_sys_aresetn`  in  1  asynchronous active-low reset.
- `i_cfg_wr`  in  1  shadow register write strobe.
- `i_cfg_addr`  in  2  shadow select: 0 contrast, 1 upper, 2 lower, 3 thr_en (bit 0 only).
- `i_cfg_wdata`  in  DATA_WIDTH  write data.
- `i_cfg_commit`  in  1  request to apply the shadow set.
- `i_err_clr`  in  1  clears sticky error flags.
- `s_axis_tvalid`, `s_axis_tready`, `s_axis_tuser`, `s_axis_tlast`  in  1 each  monitored handshake.
- `o_contrast_threshold`, `o_upper_bound`, `o_lower_bound`  out  DATA_WIDTH  active parameters.
- `o_thresholding_en`  out  1  active enable.
- `o_cfg_pending`  out  1  a commit is staged and not yet applied.
- `o_cfg_err`  out  1  one-cycle pulse when a commit is rejected.
- `o_busy`  out  1  a frame is in progress.
- `o_frame_done`  out  1  one-cycle pulse when a frame completes.
- `o_frame_cnt`  out  16  completed frames; wraps.
- `o_err_line_len`, `o_err_frame_len`  out  1  sticky error flags.

## Operation
- A beat is `s_axis_tvalid & s_axis_tready`. The SOF beat is a beat with `tuser` set.
- Shadow writes are accepted at any time. Shadow registers reset to the `DEF_*` values.
- Commit validation:
  - A commit with shadow lower ≥ shadow upper is rejected: `o_cfg_err` pulses and nothing is staged.
  - Otherwise the shadow set is copied into a staged set and `o_cfg_pending` rises.
  - A later commit overwrites the staged set (latest wins).
- FSM states are IDLE and ACTIVE.
- IDLE:
  - Beats without `tuser` are ignored.
  - An SOF beat moves to ACTIVE with x=1, y=0.
  - A staged set is applied to the outputs and pending is cleared, unless an SOF beat occurs in the same cycle. In that case application is deferred to the end of that frame.
- ACTIVE, line tracking:
  - Each beat increments x.
  - A beat with `tlast` ends the line: x=0, y++.
  - If `tlast` arrives when x ≠ WIDTH-1, `o_err_line_len` is set.
  - A beat at x=WIDTH-1 without `tlast` sets `o_err_line_len` and force-ends the line.
- ACTIVE, frame tracking:
  - An SOF beat sets `o_err_frame_len` and restarts the frame (x=1, y=0). No `o_frame_done` is issued.
  - A line end at y=HEIGHT-1 completes the frame: `o_frame_done` pulses, `o_frame_cnt` increments, the FSM returns to IDLE, and any staged set is applied.
- Error flags: `i_err_clr` clears both. If an error is set in the same cycle, the set wins.
- Arithmetic: x counter is $clog2(WIDTH) bits; y counter is $clog2(HEIGHT) bits; `o_frame_cnt` wraps 0xFFFF→0.

## Timing
- All outputs are registered.
- Reset values:
  - Parameter outputs: the `DEF_*` values.
  - All flags, pulses and counters: 0.
  - FSM: IDLE.
- Commit latency:
  - IDLE commit sampled at edge T: new parameters and `o_cfg_pending`=0 are visible after edge T+1 (stage at T, apply at T+1).
  - `o_cfg_pending` is high for exactly one cycle in this case.
- End-of-frame: the final beat sampled at edge T produces all of the following after edge T:
  - `o_frame_done`=1 for one cycle.
  - `o_busy`=0.
  - Staged parameters applied.
- A commit arriving on the final-beat edge is staged. It is applied one cycle later, because the FSM is then in IDLE.
- Parameters never change while `o_busy`=1.
- Reset mid-frame returns to IDLE with default parameters and discards the staged set.

## Structure
- `hist_eq_pkg` holds:
  - the FSM state enum `hist_eq_ctrl_state_t`;
  - the shadow address constants `CFG_ADDR_CONTRAST`=0, `CFG_ADDR_UPPER`=1, `CFG_ADDR_LOWER`=2, `CFG_ADDR_THR_EN`=3;
  - a parameter-set struct `hist_eq_cfg_t`.
- Sub-module `hist_eq_frame_tracker` owns the FSM, the x/y counters, the error detection and `o_frame_done`. It exports `frame_end` and `sof_idle` strobes to the config logic in `hist_eq_ctrl`.

## Test plan
All scenarios use WIDTH=16, HEIGHT=8.
- Reset: release reset → outputs 170/250/100/1, `o_busy`=0, `o_frame_cnt`=0, no flags set.
- IDLE commit: write addr0=200, then commit → `o_contrast_threshold`=200 two cycles after commit; `o_cfg_pending` high for one cycle.
- Mid-frame commit: write addr2=50 and commit during line 3 → `o_lower_bound` stays 100 until the final beat (y=7, x=15, `tlast`), then reads 50 in the same cycle as the `o_frame_done` pulse; `o_frame_cnt`=1.
- Short line: `tlast` at x=9 on line 2 → `o_err_line_len`=1; y advances to 3; `i_err_clr` → 0.
- Early SOF: `tuser` beat on line 4 → `o_err_frame_len`=1; `o_frame_done` pulses only after 8 full lines counted from the new SOF.
- Invalid commit: shadow lower=250, upper=100, commit → `o_cfg_err` one-cycle pulse; `o_cfg_pending`=0; outputs unchanged.
